// File: rtl/operand_stack.sv
// ---------------------------------------------------------------------------
// operand_stack
//   JVM operand stack feeding the ALU. The top two entries are held in
//   dedicated registers (tos_o / nos_o) so the ALU sees them with no
//   read latency; all deeper entries live in a plain storage array that is
//   only touched when an entry crosses the NOS boundary.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   cmd_i[2:0] : 000 NOP, 001 PUSH, 010 POP, 011 POP2, 100 BINOP,
//                101 DUP, 110 SWAP, 111 reserved (NOP)
//   data_i     : push value (PUSH) or ALU result_lo (BINOP)
//   tos_o      : top entry, 0 when empty
//   nos_o      : second entry, 0 when fewer than two entries
//   count_o    : number of entries
//   empty_o    : count_o == 0
//   full_o     : count_o == DEPTH
//   err_o      : sticky overflow/underflow flag, cleared only by reset
//   err_code_o : (only with OPSTACK_ERR_CODE_EN) first error since reset,
//                00 none, 01 overflow, 10 underflow
//
// Optional feature macro: OPSTACK_ERR_CODE_EN
// ---------------------------------------------------------------------------
module operand_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 cmd_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           tos_o,
    output logic [WIDTH-1:0]           nos_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       err_o
`ifdef OPSTACK_ERR_CODE_EN
    ,
    output logic [1:0]                 err_code_o
`endif
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int DEEP = (DEPTH > 2) ? DEPTH - 2 : 1;
    localparam int AW   = (DEEP > 1) ? $clog2(DEEP) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        NOP   = 3'b000,
        PUSH  = 3'b001,
        POP   = 3'b010,
        POP2  = 3'b011,
        BINOP = 3'b100,
        DUP   = 3'b101,
        SWAP  = 3'b110,
        RSVD  = 3'b111
    } cmd_e;

    cmd_e cmd;
    assign cmd = cmd_e'(cmd_i);

    // Entry k of the stack (0 = bottom) lives in deep[k] for k < count-2.
    logic [WIDTH-1:0] deep [2**AW];

    logic [AW-1:0]    idx2, idx3, idx4;
    logic             has1, has2, has3, has4;
    logic [WIDTH-1:0] below_nos, below_2;

    logic [WIDTH-1:0] nxt_tos, nxt_nos;
    logic [CW-1:0]    nxt_count;
    logic             deep_we, ovf, unf;

    assign has1 = (count_o != '0);
    assign has2 = (count_o > CW'(1));
    assign has3 = (count_o > CW'(2));
    assign has4 = (count_o > CW'(3));

    // idx2 is where NOS goes when something is pushed over it; idx3/idx4
    // are the entries that surface into NOS/TOS when the top shrinks.
    assign idx2 = AW'(count_o - CW'(2));
    assign idx3 = AW'(count_o - CW'(3));
    assign idx4 = AW'(count_o - CW'(4));

    assign below_nos = has3 ? deep[idx3] : '0;
    assign below_2   = has4 ? deep[idx4] : '0;

    always_comb begin
        nxt_tos   = tos_o;
        nxt_nos   = nos_o;
        nxt_count = count_o;
        deep_we   = 1'b0;
        ovf       = 1'b0;
        unf       = 1'b0;
        case (cmd)
            PUSH: begin
                if (count_o == FULL_CNT) begin
                    ovf = 1'b1;
                end else begin
                    deep_we   = has2;
                    nxt_nos   = tos_o;
                    nxt_tos   = data_i;
                    nxt_count = count_o + CW'(1);
                end
            end
            POP: begin
                if (!has1) begin
                    unf = 1'b1;
                end else begin
                    nxt_tos   = nos_o;
                    nxt_nos   = below_nos;
                    nxt_count = count_o - CW'(1);
                end
            end
            POP2: begin
                if (!has2) begin
                    unf = 1'b1;
                end else begin
                    nxt_tos   = below_nos;
                    nxt_nos   = below_2;
                    nxt_count = count_o - CW'(2);
                end
            end
            BINOP: begin
                // Net -1 entry, so it can never overflow even when full.
                if (!has2) begin
                    unf = 1'b1;
                end else begin
                    nxt_tos   = data_i;
                    nxt_nos   = below_nos;
                    nxt_count = count_o - CW'(1);
                end
            end
            DUP: begin
                if (!has1) begin
                    unf = 1'b1;
                end else if (count_o == FULL_CNT) begin
                    ovf = 1'b1;
                end else begin
                    deep_we   = has2;
                    nxt_nos   = tos_o;
                    nxt_count = count_o + CW'(1);
                end
            end
            SWAP: begin
                if (!has2) begin
                    unf = 1'b1;
                end else begin
                    nxt_tos = nos_o;
                    nxt_nos = tos_o;
                end
            end
            default: ;
        endcase
    end

    // ---- state register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            tos_o   <= '0;
            nos_o   <= '0;
            count_o <= '0;
            err_o   <= 1'b0;
        end else begin
            tos_o   <= nxt_tos;
            nos_o   <= nxt_nos;
            count_o <= nxt_count;
            if (ovf || unf) begin
                err_o <= 1'b1;
            end
        end
    end

    // Storage below NOS carries no reset; count_o alone defines validity.
    always_ff @(posedge clk) begin
        if (deep_we && !rst) begin
            deep[idx2] <= nos_o;
        end
    end

`ifdef OPSTACK_ERR_CODE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_code_o <= 2'b00;
        end else if (err_code_o == 2'b00 && (ovf || unf)) begin
            err_code_o <= ovf ? 2'b01 : 2'b10;
        end
    end
`endif

    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == FULL_CNT);

endmodule

// File: tb/tb_operand_stack.sv
// ---------------------------------------------------------------------------
// tb_operand_stack
//   Directed test-plan sequence followed by a randomized command stream,
//   all checked against a queue-based model of the operand stack.
// ---------------------------------------------------------------------------
module tb_operand_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_PUSH  = 3'd1;
    localparam logic [2:0] C_POP   = 3'd2;
    localparam logic [2:0] C_POP2  = 3'd3;
    localparam logic [2:0] C_BINOP = 3'd4;
    localparam logic [2:0] C_DUP   = 3'd5;
    localparam logic [2:0] C_SWAP  = 3'd6;
    localparam logic [2:0] C_RSVD  = 3'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       cmd = C_NOP;
    logic [WIDTH-1:0] data = '0;
    logic [WIDTH-1:0] tos, nos;
    logic [CW-1:0]    count;
    logic             empty, full, err;
`ifdef OPSTACK_ERR_CODE_EN
    logic [1:0]       err_code;
`endif

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_i   (cmd),
        .data_i  (data),
        .tos_o   (tos),
        .nos_o   (nos),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full),
        .err_o   (err)
`ifdef OPSTACK_ERR_CODE_EN
        ,
        .err_code_o (err_code)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the stack is a queue, back = top.
    logic [WIDTH-1:0] q[$];
    bit               m_err  = 1'b0;
    logic [1:0]       m_code = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] c, input logic [WIDTH-1:0] d, input bit r);
        int n;
        bit ovf, unf;
        logic [WIDTH-1:0] a, b;
        if (r) begin
            q.delete();
            m_err  = 1'b0;
            m_code = 2'b00;
            return;
        end
        n   = q.size();
        ovf = (c == C_PUSH || c == C_DUP) && n == DEPTH;
        unf = ((c == C_POP || c == C_DUP) && n == 0) ||
              ((c == C_POP2 || c == C_BINOP || c == C_SWAP) && n < 2);
        if (ovf || unf) begin
            if (m_code == 2'b00) m_code = ovf ? 2'b01 : 2'b10;
            m_err = 1'b1;
            return;
        end
        case (c)
            C_PUSH:  q.push_back(d);
            C_POP:   a = q.pop_back();
            C_POP2:  begin a = q.pop_back(); b = q.pop_back(); end
            C_BINOP: begin a = q.pop_back(); b = q.pop_back(); q.push_back(d); end
            C_DUP:   q.push_back(q[n-1]);
            C_SWAP:  begin a = q.pop_back(); b = q.pop_back(); q.push_back(a); q.push_back(b); end
            default: ;
        endcase
    endtask

    function automatic logic [WIDTH-1:0] m_tos();
        return (q.size() > 0) ? q[q.size()-1] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] m_nos();
        return (q.size() > 1) ? q[q.size()-2] : '0;
    endfunction

    // Apply one command for one clock, update the model, and compare all outputs.
    task automatic step(input logic [2:0] c, input logic [WIDTH-1:0] d, input bit r);
        @(negedge clk);
        cmd  = c;
        data = d;
        rst  = r;
        @(posedge clk);
        model(c, d, r);
        #1;
        chk("tos",   tos,   m_tos());
        chk("nos",   nos,   m_nos());
        chk("count", 32'(count), q.size());
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full",  32'(full),  32'(q.size() == DEPTH));
        chk("err",   32'(err),   32'(m_err));
`ifdef OPSTACK_ERR_CODE_EN
        chk("err_code", 32'(err_code), 32'(m_code));
`endif
    endtask

    initial begin
        logic [2:0]       c;
        logic [WIDTH-1:0] d;
        bit               r;
        int               w;

        // Reset state
        step(C_NOP, '0, 1'b1);
        step(C_NOP, '0, 1'b1);
        chk("rst_count", 32'(count), 0);
        chk("rst_tos",   tos, 0);
        chk("rst_nos",   nos, 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full",  32'(full), 0);
        chk("rst_err",   32'(err), 0);

        // Two pushes then an iadd result
        step(C_PUSH, 32'hFF, 1'b0);
        step(C_PUSH, 32'hFF, 1'b0);
        chk("pp_count", 32'(count), 2);
        chk("pp_tos", tos, 32'hFF);
        chk("pp_nos", nos, 32'hFF);
        step(C_BINOP, 32'h1FE, 1'b0);
        chk("bin_count", 32'(count), 1);
        chk("bin_tos", tos, 32'h1FE);
        chk("bin_nos", nos, 0);

        // Swap, then pop both, earlier entry intact
        step(C_PUSH, 32'h10, 1'b0);
        step(C_PUSH, 32'h20, 1'b0);
        step(C_SWAP, '0, 1'b0);
        chk("swap_tos", tos, 32'h10);
        chk("swap_nos", nos, 32'h20);
        step(C_POP2, '0, 1'b0);
        chk("pop2_count", 32'(count), 1);
        chk("pop2_tos", tos, 32'h1FE);

        // Fill, overflow, drain
        step(C_NOP, '0, 1'b1);
        for (int i = 1; i <= DEPTH; i++) step(C_PUSH, 32'(i), 1'b0);
        chk("fill_full", 32'(full), 1);
        chk("fill_tos", tos, DEPTH);
        step(C_PUSH, 32'hAA, 1'b0);
        chk("ovf_err", 32'(err), 1);
        chk("ovf_tos", tos, DEPTH);
        chk("ovf_count", 32'(count), DEPTH);
        step(C_BINOP, 32'h1F, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            chk("drain_tos", tos, (i == 0) ? 32'h1F : 32'(DEPTH - 1 - i));
            step(C_POP, '0, 1'b0);
        end
        chk("drain_empty", 32'(empty), 1);

        // Underflow from empty, then overflow does not overwrite the code
        step(C_NOP, '0, 1'b1);
        step(C_POP, '0, 1'b0);
        chk("unf_err", 32'(err), 1);
        chk("unf_count", 32'(count), 0);
`ifdef OPSTACK_ERR_CODE_EN
        chk("unf_code", 32'(err_code), 2);
`endif
        for (int i = 0; i <= DEPTH; i++) step(C_PUSH, 32'(i + 100), 1'b0);
`ifdef OPSTACK_ERR_CODE_EN
        chk("unf_code_kept", 32'(err_code), 2);
`endif

        // Reset beats a same-cycle push; DUP on a single entry
        step(C_PUSH, 32'h5, 1'b1);
        chk("rstpush_count", 32'(count), 0);
        chk("rstpush_tos", tos, 0);
        chk("rstpush_err", 32'(err), 0);
        step(C_PUSH, 32'h7, 1'b0);
        step(C_DUP, '0, 1'b0);
        chk("dup_tos", tos, 32'h7);
        chk("dup_nos", nos, 32'h7);
        chk("dup_count", 32'(count), 2);
        step(C_RSVD, 32'h99, 1'b0);

        // Randomized stream, alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 1500; i++) begin
            w = $urandom_range(0, 99);
            if (((i / 120) % 2) == 0)
                c = (w < 45) ? C_PUSH : (w < 55) ? C_DUP : (w < 70) ? C_BINOP :
                    (w < 80) ? C_SWAP : (w < 88) ? C_POP : (w < 93) ? C_POP2 :
                    3'($urandom_range(0, 7));
            else
                c = (w < 15) ? C_PUSH : (w < 20) ? C_DUP : (w < 35) ? C_BINOP :
                    (w < 45) ? C_SWAP : (w < 70) ? C_POP : (w < 85) ? C_POP2 :
                    3'($urandom_range(0, 7));
            d = $urandom;
            if (c == C_BINOP && q.size() >= 2) d = m_nos() + m_tos();
            r = ($urandom_range(0, 199) == 0);
            step(c, d, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- JVM operand stack that sits directly upstream of the ALU.
- Holds 32-bit words and presents the top two entries as registered outputs:
  - nos_o (next-of-stack, value1) drives alu.operand_a.
  - tos_o (top-of-stack, value2) drives alu.operand_b.
- The decode stage issues one command per cycle.
- A BINOP command consumes both operands and pushes the ALU result_lo in the same cycle.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 16, maximum number of entries; must be at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_i  input  3  command: 000 NOP, 001 PUSH, 010 POP, 011 POP2, 100 BINOP, 101 DUP, 110 SWAP, 111 reserved (treated as NOP).
- data_i  input  WIDTH  push value for PUSH, or ALU result_lo for BINOP.
- tos_o  output  WIDTH  top entry; 0 when the stack is empty.
- nos_o  output  WIDTH  second entry; 0 when count_o < 2.
- count_o  output  $clog2(DEPTH+1)  current number of entries.
- empty_o  output  1  high when count_o == 0.
- full_o  output  1  high when count_o == DEPTH.
- err_o  output  1  sticky error flag, set on overflow or underflow.

Behaviour:
- Reset (rst high at clk edge):
  - count_o = 0, tos_o = 0, nos_o = 0, err_o = 0, empty_o = 1, full_o = 0.
  - Reset takes priority over any cmd_i issued in the same cycle.
  - Reset mid-sequence discards all entries.
- Latency: every command completes in one cycle. All outputs reflect the post-command state after that edge. There is no stall and no ready signal.
- Commands (legal case):
  - PUSH: data_i becomes TOS, old TOS becomes NOS; count +1.
  - POP: discards TOS; count -1.
  - POP2: discards TOS and NOS; count -2.
  - BINOP: removes TOS and NOS, pushes data_i; count -1. data_i is combinationally f(nos_o, tos_o) from the ALU.
  - DUP: copies TOS to a new top entry; count +1.
  - SWAP: exchanges TOS and NOS; count unchanged.
- Illegal command: the command is ignored entirely (no state change except err_o <= 1). err_o stays high until reset.
  - Overflow: PUSH or DUP when count == DEPTH.
  - Underflow: POP or DUP when count == 0; POP2, BINOP or SWAP when count < 2.
- BINOP never overflows, including at full.
- Deeper entries (below NOS) are preserved exactly across all commands. Order is strict LIFO.
- Vacated output positions read 0. After popping to one entry, nos_o = 0; after popping to empty, tos_o = 0 and nos_o = 0.
- full_o and empty_o are decoded from the registered count, so both track count_o with no extra latency.

Optional Feature:
- Macro: OPSTACK_ERR_CODE_EN.
- Defined: adds output err_code_o [1:0] recording the first error since reset.
  - 00 none, 01 overflow, 10 underflow.
  - Later errors do not overwrite it; reset clears it to 00.
- Undefined: the port does not exist and only err_o reports errors.

Test Plan:
- Reset, then PUSH 0xFF, then PUSH 0xFF -> count_o = 2, tos_o = 0xFF, nos_o = 0xFF, err_o = 0.
- From that state, BINOP with data_i = 0x1FE (iadd result) -> count_o = 1, tos_o = 0x1FE, nos_o = 0.
- PUSH 0x10, PUSH 0x20, SWAP -> tos_o = 0x10, nos_o = 0x20. Then POP2 -> count_o returns to its prior value and the earlier entry is intact.
- Fill to DEPTH = 16 with PUSH 1..16 -> full_o = 1, tos_o = 16. A 17th PUSH 0xAA -> err_o = 1, tos_o still 16, count_o = 16. POP x16 -> values read out 16..1 in order, empty_o = 1.
- After reset, POP -> err_o = 1, count_o = 0. With OPSTACK_ERR_CODE_EN, err_code_o = 10, and a subsequent overflow leaves err_code_o at 10.
- PUSH 0x5 with rst asserted in the same cycle -> count_o = 0, tos_o = 0, err_o = 0. DUP on a single entry 0x7 -> tos_o = nos_o = 0x7, count_o = 2.
